// File: rtl/pe_pkg.sv
// pe_pkg: shared constants, loader state encoding and the product
// round/shift/saturate helper for the weight-stationary PE array.
package pe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned PROD_W         = 2 * DATA_WIDTH_DEF;
  // Working width of sat_round; wide enough for any 2*DATA_WIDTH product up to 62 bits.
  localparam int unsigned SAT_W          = 64;

  typedef enum logic {
    L_FILL = 1'b0,
    L_FULL = 1'b1
  } ld_state_e;

  // Round half up, arithmetic shift right by frac_bits, clamp to data_width signed range.
  function automatic logic signed [SAT_W-1:0] sat_round(
    input logic signed [SAT_W-1:0] prod,
    input int unsigned             frac_bits,
    input int unsigned             data_width
  );
    logic signed [SAT_W-1:0] rnd;
    logic signed [SAT_W-1:0] shf;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    rnd = prod;
    if (frac_bits > 0) begin
      rnd = prod + signed'(SAT_W'(1) << (frac_bits - 1));
    end
    shf   = rnd >>> frac_bits;
    max_v = signed'((SAT_W'(1) << (data_width - 1)) - SAT_W'(1));
    min_v = ~max_v;
    if (shf > max_v) begin
      return max_v;
    end else if (shf < min_v) begin
      return min_v;
    end
    return shf;
  endfunction

endpackage

// File: rtl/pe_lane.sv
// pe_lane: one multiply lane. S1 registers the full signed product,
// S2 registers the rounded, shifted and saturated result.
//  clk, rst       : clock, synchronous active-high reset
//  s1_en_i        : load S1 product register
//  s2_en_i        : load S2 result register
//  act_i, wt_i    : activation and weight (signed)
//  mult_o         : registered lane result
module pe_lane
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PROD_W / 2,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  logic [DATA_WIDTH-1:0] act_i,
  input  logic [DATA_WIDTH-1:0] wt_i,
  output logic [DATA_WIDTH-1:0] mult_o
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]   prod_q;
  logic [DATA_WIDTH-1:0]  mult_q;

  // Two-stage multiply then round/saturate
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      mult_q <= '0;
    end else begin
      if (s1_en_i) begin
        prod_q <= PW'(signed'(act_i)) * PW'(signed'(wt_i));
      end
      if (s2_en_i) begin
        mult_q <= DATA_WIDTH'(sat_round(SAT_W'(prod_q), FRAC_BITS, DATA_WIDTH));
      end
    end
  end

  assign mult_o = mult_q;

endmodule

// File: rtl/pe_array_kxk.sv
// pe_array_kxk: KxK weight-stationary multiply array with a double-buffered
// kernel. Rows stream into the shadow bank; once full it is swapped into the
// active bank on a cycle where no window is accepted.
//  clk, rst                          : clock, synchronous active-high reset
//  wt_valid/wt_ready/wt_row/wt_last  : kernel row stream, col0 in MSB slice
//  act_valid/act_ready/activation    : window stream, element (0,0) in MSB slice
//  prod_valid/prod_ready/multiply    : product stream, same lane order
//  kernel_rdy                        : active bank holds a complete kernel
//  load_err                          : sticky wt_last/row-index mismatch
module pe_array_kxk
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned K          = 3,
  parameter int unsigned FRAC_BITS  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wt_valid,
  output logic                      wt_ready,
  input  logic [DATA_WIDTH*K-1:0]   wt_row,
  input  logic                      wt_last,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [DATA_WIDTH*K*K-1:0] activation,
  output logic                      prod_valid,
  input  logic                      prod_ready,
  output logic [DATA_WIDTH*K*K-1:0] multiply,
  output logic                      kernel_rdy,
  output logic                      load_err
);

  localparam int unsigned KK  = K * K;
  localparam int unsigned RCW = (K > 1) ? $clog2(K) : 1;

  logic [DATA_WIDTH-1:0] shadow_q [KK];
  logic [DATA_WIDTH-1:0] active_q [KK];

  ld_state_e      state_q, state_d;
  logic [RCW-1:0] rc_q, rc_d;
  logic           load_err_q, load_err_d;
  logic           kernel_rdy_q, kernel_rdy_d;
  logic           wt_ready_q, wt_ready_d;
  logic           v1_q, prod_valid_q;

  logic wt_fire, last_row, swap, en, act_fire;

  assign wt_fire   = wt_valid & wt_ready_q;
  assign last_row  = (rc_q == RCW'(K - 1));
  // The swap owns the first L_FULL cycle; windows are held off for that cycle only.
  assign swap      = (state_q == L_FULL);
  assign en        = ~prod_valid_q | prod_ready;
  assign act_ready = kernel_rdy_q & en & ~swap;
  assign act_fire  = act_valid & act_ready;

  // Loader next-state logic
  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    load_err_d   = load_err_q;
    kernel_rdy_d = kernel_rdy_q;
    case (state_q)
      L_FILL: begin
        if (wt_fire) begin
          if (wt_last != last_row) begin
            load_err_d = 1'b1;
          end
          if (last_row) begin
            rc_d    = '0;
            state_d = L_FULL;
          end else begin
            rc_d = rc_q + RCW'(1);
          end
        end
      end
      L_FULL: begin
        kernel_rdy_d = 1'b1;
        state_d      = L_FILL;
      end
      default: state_d = L_FILL;
    endcase
    wt_ready_d = (state_d == L_FILL);
  end

  // Loader state, banks and pipeline valids
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= L_FILL;
      rc_q         <= '0;
      load_err_q   <= 1'b0;
      kernel_rdy_q <= 1'b0;
      wt_ready_q   <= 1'b1;
      v1_q         <= 1'b0;
      prod_valid_q <= 1'b0;
      for (int unsigned i = 0; i < KK; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      load_err_q   <= load_err_d;
      kernel_rdy_q <= kernel_rdy_d;
      wt_ready_q   <= wt_ready_d;
      if (en) begin
        v1_q         <= act_fire;
        prod_valid_q <= v1_q;
      end
      if (wt_fire) begin
        for (int unsigned r = 0; r < K; r++) begin
          if (rc_q == RCW'(r)) begin
            for (int unsigned c = 0; c < K; c++) begin
              shadow_q[r*K + c] <= wt_row[DATA_WIDTH*(K-c)-1 -: DATA_WIDTH];
            end
          end
        end
      end
      if (swap) begin
        for (int unsigned i = 0; i < KK; i++) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  // Lane array; S2 loads only behind a valid S1 so idle cycles keep the last result
  for (genvar i = 0; i < KK; i++) begin : g_lane
    pe_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .s1_en_i (en & act_fire),
      .s2_en_i (en & v1_q),
      .act_i   (activation[DATA_WIDTH*(KK-i)-1 -: DATA_WIDTH]),
      .wt_i    (active_q[i]),
      .mult_o  (multiply[DATA_WIDTH*(KK-i)-1 -: DATA_WIDTH])
    );
  end

  assign wt_ready   = wt_ready_q;
  assign prod_valid = prod_valid_q;
  assign kernel_rdy = kernel_rdy_q;
  assign load_err   = load_err_q;

endmodule
